// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the register-file write port between the ALU (priority)
//            and a buffered LSU writeback path; tracks outstanding loads.
// Option   : RF_WB_STARVE_GUARD_EN - forces an LSU grant after STARVE_LIM
//            waiting cycles, stalling the ALU for that one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NREG       = 32,
    parameter int QDEPTH     = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       alu_stall,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [ADDR_W-1:0]          lsu_rd,
    input  logic [DATA_W-1:0]          lsu_data,
    input  logic                       issue_valid,
    input  logic                       issue_is_load,
    input  logic [ADDR_W-1:0]          issue_rd,
    input  logic [ADDR_W-1:0]          chk_rs1,
    input  logic [ADDR_W-1:0]          chk_rs2,
    input  logic [ADDR_W-1:0]          chk_rd,
    output logic                       hazard,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic [NREG-1:0]            busy_mask,
    output logic [$clog2(QDEPTH):0]    fifo_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || STARVE_LIM < 1 ||
        NREG != (1 << ADDR_W)) begin : g_param_check
        $error("regfile_wb_arbiter: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // LSU writeback FIFO
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fifo_rd_mem   [QDEPTH];
    logic [DATA_W-1:0] fifo_data_mem [QDEPTH];

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(QDEPTH));
    assign lsu_ready  = !fifo_full;
    assign push       = lsu_valid && lsu_ready;
    assign head_rd    = fifo_rd_mem[rptr_q];
    assign head_data  = fifo_data_mem[rptr_q];
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wptr_q]   <= lsu_rd;
            fifo_data_mem[wptr_q] <= lsu_data;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic starve;
    logic grant_alu;
    logic grant_lsu;

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIM + 1);

    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

    assign starve    = !fifo_empty && (starve_cnt_q == SC_W'(STARVE_LIM));
    assign alu_stall = starve && alu_valid;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || grant_lsu) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SC_W'(STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve    = 1'b0;
    assign alu_stall = 1'b0;
`endif

    assign grant_lsu = starve || (!alu_valid && !fifo_empty);
    assign grant_alu = !starve && alu_valid;
    assign pop       = grant_lsu;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // ------------------------------------------------------------------
    // Registered register-file write port
    // ------------------------------------------------------------------
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // x0 grants are consumed and still load address/data, but never write.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_alu) begin
            wr_en_d   = (alu_rd != '0);
            wr_addr_d = alu_rd;
            wr_data_d = alu_data;
        end else if (grant_lsu) begin
            wr_en_d   = (head_rd != '0);
            wr_addr_d = head_rd;
            wr_data_d = head_data;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // ------------------------------------------------------------------
    // Outstanding-load scoreboard
    // ------------------------------------------------------------------
    logic [NREG-1:0] busy_q, busy_d;

    // Clear first so a same-edge set for a newly issued load wins.
    always_comb begin
        busy_d = busy_q;
        if (grant_lsu) begin
            busy_d[head_rd] = 1'b0;
        end
        if (issue_valid && issue_is_load && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign busy_mask = busy_q;
    assign hazard    = busy_q[chk_rs1] || busy_q[chk_rs2] || busy_q[chk_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter; expected writes are
//            queued at drive time and popped when wr_en is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int QDEPTH = 2;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    alu_valid = 1'b0;
    logic [ADDR_W-1:0]       alu_rd = '0;
    logic [DATA_W-1:0]       alu_data = '0;
    logic                    alu_stall;
    logic                    lsu_valid = 1'b0;
    logic                    lsu_ready;
    logic [ADDR_W-1:0]       lsu_rd = '0;
    logic [DATA_W-1:0]       lsu_data = '0;
    logic                    issue_valid = 1'b0;
    logic                    issue_is_load = 1'b0;
    logic [ADDR_W-1:0]       issue_rd = '0;
    logic [ADDR_W-1:0]       chk_rs1 = '0;
    logic [ADDR_W-1:0]       chk_rs2 = '0;
    logic [ADDR_W-1:0]       chk_rd = '0;
    logic                    hazard;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [NREG-1:0]         busy_mask;
    logic [$clog2(QDEPTH):0] fifo_count;

    int  vectors = 0;
    int  miscompares = 0;
    wb_t exp_q[$];

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .QDEPTH(QDEPTH), .STARVE_LIM(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_mask(busy_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        wb_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Every observed register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check_eq("sb_addr", 64'(wr_addr), 64'(e.rd));
                check_eq("sb_data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic [NREG-1:0]   busy_snap;
        int                stall_at;
`ifdef RF_WB_STARVE_GUARD_EN
        stall_at = 5;
`else
        stall_at = -1;
`endif

        // Reset state
        tick();
        tick();
        check_eq("rst_wr_en",     64'(wr_en),      64'd0);
        check_eq("rst_wr_addr",   64'(wr_addr),    64'd0);
        check_eq("rst_wr_data",   64'(wr_data),    64'd0);
        check_eq("rst_fifo_cnt",  64'(fifo_count), 64'd0);
        check_eq("rst_busy",      64'(busy_mask),  64'd0);
        check_eq("rst_lsu_ready", 64'(lsu_ready),  64'd1);
        check_eq("rst_alu_stall", 64'(alu_stall),  64'd0);
        rst_n = 1'b1;
        tick();

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        #1;
        check_eq("alu_stall0", 64'(alu_stall), 64'd0);
        tick();
        alu_valid = 1'b0;
        check_eq("alu_wr_en",   64'(wr_en),   64'd1);
        check_eq("alu_wr_addr", 64'(wr_addr), 64'd5);
        check_eq("alu_wr_data", 64'(wr_data), 64'hDEADBEEF);
        tick();
        check_eq("alu_wr_idle", 64'(wr_en), 64'd0);

        // Load scoreboard
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk_rs1 = 5'd7;
        #1;
        check_eq("busy7_set", 64'(busy_mask[7]), 64'd1);
        check_eq("hazard7",   64'(hazard),       64'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
        expect_wr(5'd7, 32'h1234);
        tick();
        lsu_valid = 1'b0;
        check_eq("ld_cnt1",  64'(fifo_count), 64'd1);
        check_eq("ld_nowr",  64'(wr_en),      64'd0);
        tick();
        check_eq("ld_wr_addr", 64'(wr_addr),      64'd7);
        check_eq("ld_wr_data", 64'(wr_data),      64'h1234);
        check_eq("busy7_clr",  64'(busy_mask[7]), 64'd0);
        check_eq("hazard7_clr", 64'(hazard),      64'd0);
        chk_rs1 = 5'd0;

        // Collision: ALU wins while the FIFO holds an entry
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hB0;
        lsu_valid = 1'b1; lsu_rd = 5'd9;  lsu_data = 32'hA0;
        expect_wr(5'd10, 32'hB0);
        tick();
        lsu_valid = 1'b0;
        alu_rd = 5'd11; alu_data = 32'hC0;
        expect_wr(5'd11, 32'hC0);
        check_eq("col_cnt_a", 64'(fifo_count), 64'd1);
        tick();
        alu_valid = 1'b0;
        expect_wr(5'd9, 32'hA0);
        check_eq("col_cnt_b", 64'(fifo_count), 64'd1);
        check_eq("col_addr_b", 64'(wr_addr),   64'd11);
        tick();
        check_eq("col_cnt_c", 64'(fifo_count), 64'd0);
        check_eq("col_addr_c", 64'(wr_addr),   64'd9);

        // FIFO full with ALU continuously valid
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h12;
        lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'h13;
        expect_wr(5'd12, 32'h12);
        tick();
        alu_rd = 5'd14; alu_data = 32'h14; lsu_rd = 5'd15; lsu_data = 32'h15;
        expect_wr(5'd14, 32'h14);
        tick();
        check_eq("full_cnt2", 64'(fifo_count), 64'd2);
        alu_rd = 5'd16; alu_data = 32'h16; lsu_rd = 5'd17; lsu_data = 32'h17;
        expect_wr(5'd16, 32'h16);
        #1;
        check_eq("full_ready0", 64'(lsu_ready), 64'd0);
        tick();
        alu_valid = 1'b0;
        expect_wr(5'd13, 32'h13);
        #1;
        check_eq("full_no_pass", 64'(lsu_ready), 64'd0);
        tick();
        check_eq("drain1_cnt", 64'(fifo_count), 64'd1);
        check_eq("drain1_addr", 64'(wr_addr),   64'd13);
        check_eq("drain1_ready", 64'(lsu_ready), 64'd1);
        expect_wr(5'd15, 32'h15);
        tick();
        lsu_valid = 1'b0;
        check_eq("drain2_cnt", 64'(fifo_count), 64'd1);
        expect_wr(5'd17, 32'h17);
        tick();
        check_eq("drain3_cnt", 64'(fifo_count), 64'd0);
        check_eq("drain3_addr", 64'(wr_addr),   64'd17);

        // Starvation: ALU valid every cycle with one FIFO entry
        d = 32'h5000;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'hCAFE0020;
        for (int k = 0; k < 8; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd21; alu_data = d;
            #1;
            if (k == stall_at) begin
                check_eq("starve_stall", 64'(alu_stall), 64'd1);
                expect_wr(5'd20, 32'hCAFE0020);
            end else begin
                check_eq("starve_stall", 64'(alu_stall), 64'd0);
                expect_wr(5'd21, d);
                d = d + 32'd1;
            end
            tick();
            lsu_valid = 1'b0;
            if (k == stall_at) begin
                check_eq("starve_lsu_wr", 64'(wr_addr), 64'd20);
            end
        end
        alu_valid = 1'b0;
`ifdef RF_WB_STARVE_GUARD_EN
        check_eq("starve_drained", 64'(fifo_count), 64'd0);
`else
        check_eq("strict_prio_cnt", 64'(fifo_count), 64'd1);
        expect_wr(5'd20, 32'hCAFE0020);
        tick();
        check_eq("strict_late_wr", 64'(wr_addr), 64'd20);
`endif
        tick();

        // Same-edge set and clear of one register: set wins
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd8;
        tick();
        issue_valid = 1'b0;
        check_eq("busy8_set", 64'(busy_mask[8]), 64'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h8888;
        expect_wr(5'd8, 32'h8888);
        tick();
        lsu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd8;
        tick();
        issue_valid = 1'b0;
        check_eq("setclr_addr", 64'(wr_addr),      64'd8);
        check_eq("setclr_busy", 64'(busy_mask[8]), 64'd1);
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h8889;
        expect_wr(5'd8, 32'h8889);
        tick();
        lsu_valid = 1'b0;
        tick();
        check_eq("busy8_clr", 64'(busy_mask[8]), 64'd0);

        // x0 handling
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0BAD;
        tick();
        lsu_valid = 1'b0;
        tick();
        check_eq("x0_wr_en",   64'(wr_en),      64'd0);
        check_eq("x0_wr_data", 64'(wr_data),    64'h0BAD);
        check_eq("x0_cnt",     64'(fifo_count), 64'd0);
        busy_snap = busy_mask;
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        check_eq("x0_busy", 64'(busy_mask), 64'(busy_snap));

        // Reset mid-operation
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd22; alu_data = 32'h7000;
        lsu_valid = 1'b1; lsu_rd = 5'd23; lsu_data = 32'h23;
        expect_wr(5'd22, 32'h7000);
        tick();
        issue_valid = 1'b0;
        alu_data = 32'h7001; lsu_rd = 5'd24; lsu_data = 32'h24;
        tick();
        check_eq("pre_rst_cnt",   64'(fifo_count),   64'd2);
        check_eq("pre_rst_busy3", 64'(busy_mask[3]), 64'd1);
        check_eq("pre_rst_wr_en", 64'(wr_en),        64'd1);
        rst_n = 1'b0;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        check_eq("mid_rst_cnt",   64'(fifo_count), 64'd0);
        check_eq("mid_rst_busy",  64'(busy_mask),  64'd0);
        check_eq("mid_rst_wr_en", 64'(wr_en),      64'd0);
        check_eq("mid_rst_ready", 64'(lsu_ready),  64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("post_rst_wr_en", 64'(wr_en),      64'd0);
        check_eq("post_rst_cnt",   64'(fifo_count), 64'd0);

        tick();
        check_eq("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
